// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Multi-cycle CPU stage controller. It steps each instruction through
// FETCH -> DECODE -> EXECUTE -> MEM -> WB and drives one one-hot enable per
// stage. FETCH waits for the instruction memory and MEM waits for the data
// memory. MEM and WB are skipped per instruction when the decoder says they are
// not needed. A wait that lasts too long raises a sticky error and parks the
// sequencer in HALT. A halt request is honoured when an instruction retires.
//
// Ports:
//   clock, reset        clock; asynchronous active-high reset
//   im_ready            instruction memory has returned the instruction
//   dm_ready            data memory access has completed
//   need_mem, need_wb   decoder flags, sampled only in DECODE
//   halt_req            stop after the current instruction retires
//   enable_*            one-hot stage enables (Moore outputs of state)
//   state               FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WB=4 HALT=5
//   retire              high on the final cycle of each instruction
//   instr_count         retired-instruction count, wraps modulo 2^CNT_W
//   halted              high while in HALT
//   timeout_err         sticky wait-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter bit SKIP_MEM       = 1'b1,
    parameter bit SKIP_WB        = 1'b1,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             im_ready,
    input  logic             dm_ready,
    input  logic             need_mem,
    input  logic             need_wb,
    input  logic             halt_req,
    output logic             enable_fetch,
    output logic             enable_decode,
    output logic             enable_execute,
    output logic             enable_memaccess,
    output logic             enable_writeback,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic             halted,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    // The wait counter only has to reach TIMEOUT_CYCLES-1.
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state_q;
    state_t            state_d;
    logic              need_mem_q;
    logic              need_wb_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_inc;
    logic              wait_clr;
    logic              timeout_hit;
    logic              timeout_now;
    logic              go_mem;
    logic              go_wb;

    assign timeout_now = (TIMEOUT_CYCLES > 0) && (wait_cnt == WAIT_LAST);
    assign go_mem      = need_mem_q || !SKIP_MEM;
    assign go_wb       = need_wb_q  || !SKIP_WB;

    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path
        // that leaves one unassigned would infer a latch.
        state_d     = state_q;
        retire      = 1'b0;
        wait_inc    = 1'b0;
        timeout_hit = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (im_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout_now) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_HALT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (go_mem)     state_d = ST_MEM;
                else if (go_wb) state_d = ST_WB;
                else            retire  = 1'b1;
            end
            ST_MEM: begin
                // A MEM visit forced only by SKIP_MEM=0 does not wait for dm_ready.
                if (need_mem_q && !dm_ready) begin
                    if (timeout_now) begin
                        timeout_hit = 1'b1;
                        state_d     = ST_HALT;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end else if (go_wb) begin
                    state_d = ST_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            ST_WB: retire = 1'b1;
            ST_HALT: begin
                if (!halt_req && !timeout_err) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        // halt_req matters only on the cycle the instruction retires.
        if (retire) state_d = halt_req ? ST_HALT : ST_FETCH;
    end

    // The wait counter restarts whenever a waiting state is entered.
    assign wait_clr = (state_d != state_q) &&
                      ((state_d == ST_FETCH) || (state_d == ST_MEM));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            need_mem_q  <= 1'b0;
            need_wb_q   <= 1'b0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            instr_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the values from before this edge.
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                need_mem_q <= need_mem;
                need_wb_q  <= need_wb;
            end
            if (wait_clr)      wait_cnt <= '0;
            else if (wait_inc) wait_cnt <= wait_cnt + WAIT_W'(1);
            if (timeout_hit)   timeout_err <= 1'b1;
            if (retire)        instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign state            = state_q;
    assign enable_fetch     = (state_q == ST_FETCH);
    assign enable_decode    = (state_q == ST_DECODE);
    assign enable_execute   = (state_q == ST_EXECUTE);
    assign enable_memaccess = (state_q == ST_MEM);
    assign enable_writeback = (state_q == ST_WB);
    assign halted           = (state_q == ST_HALT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// dut_a uses the default parameters. dut_b uses SKIP_MEM=SKIP_WB=0,
// TIMEOUT_CYCLES=4 and CNT_W=4. Inputs are driven on the falling edge. Outputs
// are compared 1 time unit later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam int ST_FETCH   = 0;
    localparam int ST_DECODE  = 1;
    localparam int ST_EXECUTE = 2;
    localparam int ST_MEM     = 3;
    localparam int ST_WB      = 4;
    localparam int ST_HALT    = 5;

    localparam bit A_SKIP_MEM = 1'b1;
    localparam bit A_SKIP_WB  = 1'b1;
    localparam int A_TIMEOUT  = 16;

    logic clock;

    logic        a_reset, a_im_ready, a_dm_ready, a_need_mem, a_need_wb, a_halt_req;
    logic        a_enable_fetch, a_enable_decode, a_enable_execute;
    logic        a_enable_memaccess, a_enable_writeback;
    logic [2:0]  a_state;
    logic        a_retire, a_halted, a_timeout_err;
    logic [31:0] a_instr_count;

    logic        b_reset, b_im_ready, b_dm_ready, b_need_mem, b_need_wb, b_halt_req;
    logic        b_enable_fetch, b_enable_decode, b_enable_execute;
    logic        b_enable_memaccess, b_enable_writeback;
    logic [2:0]  b_state;
    logic        b_retire, b_halted, b_timeout_err;
    logic [3:0]  b_instr_count;

    int n_checks = 0;
    int n_err    = 0;

    multicycle_sequencer #(
        .SKIP_MEM(A_SKIP_MEM), .SKIP_WB(A_SKIP_WB),
        .TIMEOUT_CYCLES(A_TIMEOUT), .CNT_W(32)
    ) dut_a (
        .clock(clock), .reset(a_reset),
        .im_ready(a_im_ready), .dm_ready(a_dm_ready),
        .need_mem(a_need_mem), .need_wb(a_need_wb), .halt_req(a_halt_req),
        .enable_fetch(a_enable_fetch), .enable_decode(a_enable_decode),
        .enable_execute(a_enable_execute), .enable_memaccess(a_enable_memaccess),
        .enable_writeback(a_enable_writeback), .state(a_state),
        .retire(a_retire), .instr_count(a_instr_count),
        .halted(a_halted), .timeout_err(a_timeout_err)
    );

    multicycle_sequencer #(
        .SKIP_MEM(1'b0), .SKIP_WB(1'b0), .TIMEOUT_CYCLES(4), .CNT_W(4)
    ) dut_b (
        .clock(clock), .reset(b_reset),
        .im_ready(b_im_ready), .dm_ready(b_dm_ready),
        .need_mem(b_need_mem), .need_wb(b_need_wb), .halt_req(b_halt_req),
        .enable_fetch(b_enable_fetch), .enable_decode(b_enable_decode),
        .enable_execute(b_enable_execute), .enable_memaccess(b_enable_memaccess),
        .enable_writeback(b_enable_writeback), .state(b_state),
        .retire(b_retire), .instr_count(b_instr_count),
        .halted(b_halted), .timeout_err(b_timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packed view of the outputs: {state, wb, mem, ex, dec, fetch, retire, halted, err}.
    function automatic logic [10:0] got_a();
        return {a_state, a_enable_writeback, a_enable_memaccess, a_enable_execute,
                a_enable_decode, a_enable_fetch, a_retire, a_halted, a_timeout_err};
    endfunction

    function automatic logic [10:0] got_b();
        return {b_state, b_enable_writeback, b_enable_memaccess, b_enable_execute,
                b_enable_decode, b_enable_fetch, b_retire, b_halted, b_timeout_err};
    endfunction

    function automatic logic [10:0] want(input int st, input bit ret, input bit err);
        logic [4:0] en;
        en = (st < 5) ? (5'b00001 << st) : 5'b00000;
        return {3'(st), en, ret, (st == ST_HALT), err};
    endfunction

    task automatic drive_a(input bit imr, input bit dmr, input bit nm, input bit nw, input bit hr);
        @(negedge clock);
        a_reset = 1'b0; a_im_ready = imr; a_dm_ready = dmr;
        a_need_mem = nm; a_need_wb = nw; a_halt_req = hr;
        #1;
    endtask

    task automatic drive_b(input bit imr, input bit dmr, input bit nm, input bit nw, input bit hr);
        @(negedge clock);
        b_reset = 1'b0; b_im_ready = imr; b_dm_ready = dmr;
        b_need_mem = nm; b_need_wb = nw; b_halt_req = hr;
        #1;
    endtask

    // Holds reset for one cycle. The next drive_* call releases it.
    task automatic reset_a();
        @(negedge clock);
        a_reset = 1'b1;
        #1;
        check("a_reset_outputs", got_a(), want(ST_FETCH, 0, 0));
        check("a_reset_count", a_instr_count, 0);
    endtask

    task automatic reset_b();
        @(negedge clock);
        b_reset = 1'b1;
        #1;
        check("b_reset_outputs", got_b(), want(ST_FETCH, 0, 0));
        check("b_reset_count", b_instr_count, 0);
    endtask

    // Instruction-level reference model for dut_a. On leaving DECODE, the stages
    // still to visit are queued. Waiting stages advance only when ready.
    int          m_stage;
    int          m_plan[$];
    int          m_wait;
    bit          m_err;
    bit          m_nm;
    logic [31:0] m_count;

    task automatic model_reset();
        m_stage = ST_FETCH; m_plan.delete(); m_wait = 0; m_err = 0; m_nm = 0; m_count = 0;
    endtask

    task automatic model_cycle(input bit imr, input bit dmr, input bit nm, input bit nw,
                               input bit hr, output bit ret);
        bit waits;
        bit ready;
        ret = 0;
        if (m_stage == ST_HALT) begin
            if (!hr && !m_err) begin
                m_stage = ST_FETCH;
                m_wait  = 0;
            end
            return;
        end
        waits = (m_stage == ST_FETCH) || (m_stage == ST_MEM && m_nm);
        ready = (m_stage == ST_FETCH) ? imr : dmr;
        if (waits && !ready) begin
            if (A_TIMEOUT > 0 && m_wait == A_TIMEOUT - 1) begin
                m_err   = 1;
                m_stage = ST_HALT;
            end else begin
                m_wait++;
            end
            return;
        end
        if (m_stage == ST_FETCH) begin
            m_stage = ST_DECODE;
        end else if (m_stage == ST_DECODE) begin
            m_nm = nm;
            m_plan = {ST_EXECUTE};
            if (nm || !A_SKIP_MEM) m_plan.push_back(ST_MEM);
            if (nw || !A_SKIP_WB)  m_plan.push_back(ST_WB);
            m_stage = m_plan.pop_front();
        end else if (m_plan.size() > 0) begin
            m_stage = m_plan.pop_front();
        end else begin
            ret = 1;
            m_count = m_count + 1;
            m_stage = hr ? ST_HALT : ST_FETCH;
        end
        if (m_stage == ST_FETCH || m_stage == ST_MEM) m_wait = 0;
    endtask

    typedef struct {
        bit nm;
        bit nw;
        bit nm_late;   // need flags driven after DECODE; these must be ignored
        bit nw_late;
        int len;
        int seq[5];
    } vec_t;

    vec_t vecs[4];
    int   exp_a_cnt;
    int   exp_b_cnt;

    initial begin
        a_reset = 1'b1; a_im_ready = 0; a_dm_ready = 0; a_need_mem = 0; a_need_wb = 0; a_halt_req = 0;
        b_reset = 1'b1; b_im_ready = 0; b_dm_ready = 0; b_need_mem = 0; b_need_wb = 0; b_halt_req = 0;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 4, '{0, 1, 2, 4, 0}};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 5, '{0, 1, 2, 3, 4}};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 3, '{0, 1, 2, 0, 0}};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 4, '{0, 1, 2, 3, 0}};

        // ---------------- dut_a: stage sequences with readys held high -----
        reset_a();
        exp_a_cnt = 0;
        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < vecs[v].len; c++) begin
                bit nm;
                bit nw;
                nm = (c <= 1) ? vecs[v].nm : vecs[v].nm_late;
                nw = (c <= 1) ? vecs[v].nw : vecs[v].nw_late;
                drive_a(1, 1, nm, nw, 0);
                check($sformatf("seq_v%0d_c%0d", v, c), got_a(),
                      want(vecs[v].seq[c], c == vecs[v].len - 1, 0));
                check($sformatf("seq_cnt_v%0d_c%0d", v, c), a_instr_count, exp_a_cnt);
            end
            exp_a_cnt++;
        end
        drive_a(1, 1, 0, 0, 0);
        check("seq_final_count", a_instr_count, 4);
        check("seq_back_in_fetch", got_a(), want(ST_FETCH, 0, 0));

        // ---------------- dut_a: MEM held by dm_ready low for 5 cycles ------
        for (int c = 1; c < 10; c++) begin
            int st;
            bit dmr;
            st  = (c <= 2) ? c : (c <= 8) ? ST_MEM : ST_WB;
            dmr = !(c >= 3 && c <= 7);
            drive_a(1, dmr, 1, 1, 0);
            check($sformatf("memwait_c%0d", c), got_a(), want(st, c == 9, 0));
        end
        exp_a_cnt++;
        drive_a(1, 1, 0, 0, 0);
        check("memwait_count", a_instr_count, exp_a_cnt);
        check("memwait_fetch", got_a(), want(ST_FETCH, 0, 0));

        // ---------------- dut_a: halt request ------------------------------
        drive_a(1, 1, 0, 1, 0); check("halt_decode", got_a(), want(ST_DECODE, 0, 0));
        drive_a(1, 1, 0, 1, 1); check("halt_execute", got_a(), want(ST_EXECUTE, 0, 0));
        drive_a(1, 1, 0, 0, 1); check("halt_wb_retire", got_a(), want(ST_WB, 1, 0));
        exp_a_cnt++;
        drive_a(1, 1, 0, 0, 1); check("halt_enter", got_a(), want(ST_HALT, 0, 0));
        check("halt_count", a_instr_count, exp_a_cnt);
        drive_a(1, 1, 0, 0, 0); check("halt_release_cycle", got_a(), want(ST_HALT, 0, 0));
        drive_a(1, 1, 0, 0, 0); check("halt_to_fetch", got_a(), want(ST_FETCH, 0, 0));

        // ---------------- dut_a: random stimulus against the model ---------
        reset_a();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            bit imr, dmr, nm, nw, hr, ret;
            int st0;
            bit err0;
            logic [31:0] cnt0;
            imr = ($urandom_range(0, 3) != 0);
            dmr = ($urandom_range(0, 3) != 0);
            nm  = $urandom_range(0, 1);
            nw  = $urandom_range(0, 1);
            hr  = ($urandom_range(0, 15) == 0);
            drive_a(imr, dmr, nm, nw, hr);
            st0 = m_stage; err0 = m_err; cnt0 = m_count;
            model_cycle(imr, dmr, nm, nw, hr, ret);
            check($sformatf("rand_out_%0d", i), got_a(), want(st0, ret, err0));
            check($sformatf("rand_cnt_%0d", i), a_instr_count, cnt0);
        end

        // ---------------- dut_b: forced MEM/WB visits ignore dm_ready ------
        reset_b();
        for (int c = 0; c < 5; c++) begin
            drive_b(1, 0, 0, 0, 0);
            check($sformatf("noskip_c%0d", c), got_b(), want(c, c == 4, 0));
        end
        drive_b(1, 0, 0, 0, 0);
        check("noskip_fetch", got_b(), want(ST_FETCH, 0, 0));
        check("noskip_count", b_instr_count, 1);

        // ---------------- dut_b: dm_ready rises on the last allowed cycle ---
        for (int c = 1; c < 9; c++) begin
            int st;
            st = (c <= 2) ? c : (c <= 6) ? ST_MEM : (c == 7) ? ST_WB : ST_FETCH;
            drive_b(1, c >= 6, 1, 0, 0);
            check($sformatf("memedge_c%0d", c), got_b(), want(st, c == 7, 0));
        end

        // ---------------- dut_b: FETCH timeout ------------------------------
        reset_b();
        for (int c = 0; c < 4; c++) begin
            drive_b(0, 0, 0, 0, 0);
            check($sformatf("tmo_fetch_c%0d", c), got_b(), want(ST_FETCH, 0, 0));
        end
        for (int c = 0; c < 3; c++) begin
            drive_b(0, 0, 0, 0, 0);
            check($sformatf("tmo_halt_c%0d", c), got_b(), want(ST_HALT, 0, 1));
        end
        check("tmo_count", b_instr_count, 0);
        reset_b();
        for (int c = 0; c < 4; c++) begin
            drive_b(c == 3, 1, 0, 0, 0);
            check($sformatf("tmo_edge_c%0d", c), got_b(), want(ST_FETCH, 0, 0));
        end
        drive_b(1, 1, 0, 0, 0);
        check("tmo_edge_decode", got_b(), want(ST_DECODE, 0, 0));

        // ---------------- dut_b: counter wrap, reset during MEM wait -------
        reset_b();
        exp_b_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            for (int c = 0; c < 5; c++) begin
                drive_b(1, 1, $urandom_range(0, 1), $urandom_range(0, 1), 0);
                check($sformatf("wrap_i%0d_c%0d", i, c), got_b(), want(c, c == 4, 0));
                check($sformatf("wrap_cnt_i%0d_c%0d", i, c), b_instr_count, exp_b_cnt);
            end
            exp_b_cnt = (exp_b_cnt + 1) % 16;
        end
        for (int c = 0; c < 5; c++) begin
            drive_b(1, 0, 1, 1, 0);
            check($sformatf("midmem_c%0d", c), got_b(), want((c < 3) ? c : ST_MEM, 0, 0));
        end
        check("midmem_count_before", b_instr_count, 1);
        #2;
        b_reset = 1'b1;
        #1;
        check("midmem_reset_state", got_b(), want(ST_FETCH, 0, 0));
        check("midmem_reset_count", b_instr_count, 0);
        drive_b(1, 1, 0, 0, 0);
        check("midmem_after_release", got_b(), want(ST_FETCH, 0, 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
